// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared types and constants for the multi-channel clock divider.
//   div_state_e   : per-channel divider state (BYPASS, HIGH, LOW), 2-bit encoded
//   MIN_DIV_RATIO : smallest ratio that actually divides; 0 and 1 mean bypass
//   BYPASS_STATE  : state every channel takes at reset
// Optional feature macro used elsewhere in this slice: CLKDIV_TICK_EN.
// -----------------------------------------------------------------------------
package clk_div_pkg;

   typedef enum logic [1:0] {
      BYPASS = 2'b00,
      HIGH   = 2'b01,
      LOW    = 2'b10
   } div_state_e;

   localparam int         MIN_DIV_RATIO = 2;
   localparam div_state_e BYPASS_STATE  = BYPASS;

endpackage : clk_div_pkg

// File: rtl/clk_div_multi_if.sv
// -----------------------------------------------------------------------------
// clk_div_multi_if
// Register-file side bundle of the multi-channel clock divider.
//   I_clk_en      [NUM_CH]           per-channel divider enable
//   I_div_ratio   [NUM_CH*RATIO_WD]  requested ratios, channel i at [i*RATIO_WD +: RATIO_WD]
//   I_ratio_load  [NUM_CH]           one-cycle strobe capturing a channel's ratio slice
//   O_ratio_busy  [NUM_CH]           a captured ratio is still waiting to be applied
//   O_div_clk     [NUM_CH]           divided clock (reference clock while in bypass)
//   O_period_tick [NUM_CH]           one pulse per divided period (only with CLKDIV_TICK_EN)
// Modports: master = register file / bench, slave = divider.
// -----------------------------------------------------------------------------
interface clk_div_multi_if #(
   parameter int NUM_CH   = 2,
   parameter int RATIO_WD = 8
);

   logic [NUM_CH-1:0]          I_clk_en;
   logic [NUM_CH*RATIO_WD-1:0] I_div_ratio;
   logic [NUM_CH-1:0]          I_ratio_load;
   logic [NUM_CH-1:0]          O_ratio_busy;
   logic [NUM_CH-1:0]          O_div_clk;
`ifdef CLKDIV_TICK_EN
   logic [NUM_CH-1:0]          O_period_tick;

   modport master (
      output I_clk_en, I_div_ratio, I_ratio_load,
      input  O_ratio_busy, O_div_clk, O_period_tick
   );

   modport slave (
      input  I_clk_en, I_div_ratio, I_ratio_load,
      output O_ratio_busy, O_div_clk, O_period_tick
   );
`else
   modport master (
      output I_clk_en, I_div_ratio, I_ratio_load,
      input  O_ratio_busy, O_div_clk
   );

   modport slave (
      input  I_clk_en, I_div_ratio, I_ratio_load,
      output O_ratio_busy, O_div_clk
   );
`endif

endinterface : clk_div_multi_if

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One divider channel: BYPASS/HIGH/LOW state machine, phase counter, shadow
// (pending) ratio and the bypass output mux.
// Ports:
//   I_ref_clk     in   reference clock, the only clock
//   I_rst_n       in   synchronous active-low reset
//   I_clk_en      in   channel enable
//   I_div_ratio   in   requested ratio [RATIO_WD]
//   I_ratio_load  in   strobe capturing I_div_ratio into the pending register
//   O_ratio_busy  out  pending ratio not yet applied
//   O_div_clk     out  divided clock, or I_ref_clk in BYPASS
//   O_period_tick out  one-cycle pulse on entry to HIGH (only with CLKDIV_TICK_EN)
// High phase lasts ceil(N/2) cycles, low phase floor(N/2); the active ratio only
// changes at a period boundary (end of LOW) or while in BYPASS.
// -----------------------------------------------------------------------------
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int RATIO_WD  = 8,
   parameter int RST_RATIO = 0
) (
   input  logic                I_ref_clk,
   input  logic                I_rst_n,
   input  logic                I_clk_en,
   input  logic [RATIO_WD-1:0] I_div_ratio,
   input  logic                I_ratio_load,
   output logic                O_ratio_busy,
`ifdef CLKDIV_TICK_EN
   output logic                O_period_tick,
`endif
   output logic                O_div_clk
);

   localparam int                  CNT_WD      = RATIO_WD - 1;
   localparam logic [RATIO_WD-1:0] RST_RATIO_V = RATIO_WD'(RST_RATIO);
   localparam logic [RATIO_WD-1:0] MIN_RATIO_V = RATIO_WD'(MIN_DIV_RATIO);

   div_state_e          state_q, state_d;
   logic [CNT_WD-1:0]   cnt_q, cnt_d;
   logic                div_q, div_d;
   logic [RATIO_WD-1:0] ratio_q, ratio_d;
   logic [RATIO_WD-1:0] pend_q, pend_d;
   logic                pend_vld_q, pend_vld_d;
`ifdef CLKDIV_TICK_EN
   logic                tick_q, tick_d;
`endif

   logic [CNT_WD-1:0]   hi_last;
   logic [CNT_WD-1:0]   lo_last;
   logic [RATIO_WD-1:0] held_ratio;
   logic [RATIO_WD-1:0] bound_ratio;

   // Last counter value of each phase: ceil(N/2)-1 == (N-1)>>1 avoids the
   // overflow of N+1 at N = 2^RATIO_WD-1; floor(N/2)-1 for the low phase.
   assign hi_last = CNT_WD'((ratio_q - RATIO_WD'(1)) >> 1);
   assign lo_last = CNT_WD'(ratio_q >> 1) - CNT_WD'(1);

   // Ratio that takes effect now if an apply happens: a pending value wins
   // over the active one, and a load arriving in the boundary cycle wins over both.
   assign held_ratio  = pend_vld_q   ? pend_q      : ratio_q;
   assign bound_ratio = I_ratio_load ? I_div_ratio : held_ratio;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      ratio_d    = ratio_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
`ifdef CLKDIV_TICK_EN
      tick_d     = 1'b0;
`endif

      if (I_ratio_load) begin
         pend_d     = I_div_ratio;
         pend_vld_d = 1'b1;
      end

      case (state_q)
         BYPASS: begin
            // Any earlier pending ratio becomes active at this edge; a load seen
            // now stays pending and is applied on the following edge.
            ratio_d    = held_ratio;
            pend_vld_d = I_ratio_load;
            cnt_d      = '0;
            if (I_clk_en && (held_ratio >= MIN_RATIO_V)) begin
               state_d = HIGH;
               div_d   = 1'b1;
`ifdef CLKDIV_TICK_EN
               tick_d  = 1'b1;
`endif
            end else begin
               div_d   = 1'b0;
            end
         end

         HIGH: begin
            if (cnt_q == hi_last) begin
               state_d = LOW;
               cnt_d   = '0;
               div_d   = 1'b0;
            end else begin
               cnt_d   = cnt_q + CNT_WD'(1);
            end
         end

         LOW: begin
            if (cnt_q == lo_last) begin
               // Period boundary: the only place a running channel changes ratio
               // or stops, so every emitted high/low phase has full length.
               ratio_d    = bound_ratio;
               pend_vld_d = 1'b0;
               cnt_d      = '0;
               if (I_clk_en && (bound_ratio >= MIN_RATIO_V)) begin
                  state_d = HIGH;
                  div_d   = 1'b1;
`ifdef CLKDIV_TICK_EN
                  tick_d  = 1'b1;
`endif
               end else begin
                  state_d = BYPASS;
                  div_d   = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CNT_WD'(1);
            end
         end

         default: begin
            state_d = BYPASS_STATE;
            cnt_d   = '0;
            div_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge I_ref_clk) begin
      if (!I_rst_n) begin
         state_q    <= BYPASS_STATE;
         cnt_q      <= '0;
         div_q      <= 1'b0;
         ratio_q    <= RST_RATIO_V;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
`ifdef CLKDIV_TICK_EN
         tick_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         ratio_q    <= ratio_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
`ifdef CLKDIV_TICK_EN
         tick_q     <= tick_d;
`endif
      end
   end

   // div_q is a flop, so in HIGH/LOW the output has no combinational path; the
   // mux only switches right after a rising edge.
   assign O_div_clk    = (state_q == BYPASS) ? I_ref_clk : div_q;
   assign O_ratio_busy = pend_vld_q;
`ifdef CLKDIV_TICK_EN
   assign O_period_tick = tick_q;
`endif

endmodule : clk_div_chan

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
// NUM_CH independent integer clock dividers with glitch-free ratio updates.
// Ports:
//   I_ref_clk  in  reference clock, the only clock
//   I_rst_n    in  synchronous active-low reset
//   bus        clk_div_multi_if.slave: I_clk_en, I_div_ratio, I_ratio_load in;
//              O_ratio_busy, O_div_clk (and O_period_tick with CLKDIV_TICK_EN) out
// Parameters: RATIO_WD (ratio width), NUM_CH (channels), RST_RATIO (reset ratio,
// 0 = bypass). Optional macro: CLKDIV_TICK_EN adds the per-period tick output.
// -----------------------------------------------------------------------------
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int RATIO_WD  = 8,
   parameter int NUM_CH    = 2,
   parameter int RST_RATIO = 0
) (
   input  logic            I_ref_clk,
   input  logic            I_rst_n,
   clk_div_multi_if.slave  bus
);

   logic [NUM_CH-1:0] busy_w;
   logic [NUM_CH-1:0] div_clk_w;
`ifdef CLKDIV_TICK_EN
   logic [NUM_CH-1:0] tick_w;
`endif

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      clk_div_chan #(
         .RATIO_WD  (RATIO_WD),
         .RST_RATIO (RST_RATIO)
      ) u_chan (
         .I_ref_clk     (I_ref_clk),
         .I_rst_n       (I_rst_n),
         .I_clk_en      (bus.I_clk_en[gi]),
         .I_div_ratio   (bus.I_div_ratio[gi*RATIO_WD +: RATIO_WD]),
         .I_ratio_load  (bus.I_ratio_load[gi]),
         .O_ratio_busy  (busy_w[gi]),
`ifdef CLKDIV_TICK_EN
         .O_period_tick (tick_w[gi]),
`endif
         .O_div_clk     (div_clk_w[gi])
      );
   end

   assign bus.O_ratio_busy  = busy_w;
   assign bus.O_div_clk     = div_clk_w;
`ifdef CLKDIV_TICK_EN
   assign bus.O_period_tick = tick_w;
`endif

endmodule : clk_div_multi

// File: tb/tb_clk_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_div_multi
// Directed bench for clk_div_multi (NUM_CH=2, RATIO_WD=8, RST_RATIO=0).
// Each cycle the divided clock is sampled 1 time unit after the rising and the
// falling reference edge: 2'b11 = divided high, 2'b00 = divided low,
// 2'b10 = follows the reference clock (bypass).
// With CLKDIV_TICK_EN defined the per-period tick is counted as well.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clk_div_multi;

   localparam int NUM_CH   = 2;
   localparam int RATIO_WD = 8;
   localparam logic [1:0] C_HI  = 2'b11;
   localparam logic [1:0] C_LO  = 2'b00;
   localparam logic [1:0] C_BYP = 2'b10;

   logic I_ref_clk = 1'b0;
   logic I_rst_n;

   clk_div_multi_if #(.NUM_CH(NUM_CH), .RATIO_WD(RATIO_WD)) bus ();

   clk_div_multi #(
      .RATIO_WD  (RATIO_WD),
      .NUM_CH    (NUM_CH),
      .RST_RATIO (0)
   ) dut (
      .I_ref_clk (I_ref_clk),
      .I_rst_n   (I_rst_n),
      .bus       (bus)
   );

   always #5 I_ref_clk = ~I_ref_clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [1:0] cur_code [NUM_CH];
   logic       cur_busy [NUM_CH];
   int         tick_cnt [NUM_CH];
   logic [1:0] rec_code [0:599];
   logic       rec_busy [0:599];

   // One reference cycle: sample after the rising and after the falling edge.
   task automatic step();
      logic h [NUM_CH];
      @(posedge I_ref_clk);
      #1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         h[ch]        = bus.O_div_clk[ch];
         cur_busy[ch] = bus.O_ratio_busy[ch];
`ifdef CLKDIV_TICK_EN
         if (bus.O_period_tick[ch]) tick_cnt[ch]++;
`endif
      end
      @(negedge I_ref_clk);
      #1;
      for (int ch = 0; ch < NUM_CH; ch++) cur_code[ch] = {h[ch], bus.O_div_clk[ch]};
   endtask

   task automatic record(input int ch, input int n);
      for (int k = 0; k < n; k++) begin
         step();
         rec_code[k] = cur_code[ch];
         rec_busy[k] = cur_busy[ch];
      end
   endtask

   task automatic set_ratio(input int ch, input int r);
      bus.I_div_ratio[ch*RATIO_WD +: RATIO_WD] = RATIO_WD'(r);
   endtask

   // Expected code k cycles after a period start at ratio n: ceil(n/2) high, rest low.
   function automatic logic [1:0] exp_div(input int k, input int n);
      return ((k % n) < ((n + 1) / 2)) ? C_HI : C_LO;
   endfunction

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      I_rst_n = 1'b0;
      bus.I_clk_en = '0;
      bus.I_div_ratio = '0;
      bus.I_ratio_load = '0;
      step();
      step();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         n_cmp++;
         if (cur_code[ch] !== C_BYP) begin
            n_err++;
            $display("FAIL reset_bypass ch%0d: got %b expected %b", ch, cur_code[ch], C_BYP);
         end
         n_cmp++;
         if (cur_busy[ch] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy ch%0d: got %b expected 0", ch, cur_busy[ch]);
         end
      end
      // Reset ratio is 0, so enabling must not start either channel.
      I_rst_n = 1'b1;
      bus.I_clk_en = '1;
      step();
      step();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         n_cmp++;
         if (cur_code[ch] !== C_BYP) begin
            n_err++;
            $display("FAIL reset_ratio0_enabled ch%0d: got %b expected %b", ch, cur_code[ch], C_BYP);
         end
      end
      bus.I_clk_en = '0;
      $display("test_reset done");
   endtask

   // ch0: ratio 4 loaded in bypass with enable high.
   task automatic test_bypass_load();
      int bad;
      set_ratio(0, 4);
      bus.I_ratio_load[0] = 1'b1;
      bus.I_clk_en[0] = 1'b1;
      step();
      n_cmp++;
      if (cur_busy[0] !== 1'b1 || cur_code[0] !== C_BYP) begin
         n_err++;
         $display("FAIL load_capture: got busy=%b code=%b expected busy=1 code=%b", cur_busy[0], cur_code[0], C_BYP);
      end
      bus.I_ratio_load[0] = 1'b0;
      record(0, 8);
      bad = -1;
      for (int k = 0; k < 8; k++) if (bad < 0 && rec_code[k] !== exp_div(k, 4)) bad = k;
      n_cmp++;
      if (bad >= 0) begin
         n_err++;
         $display("FAIL ratio4_wave: cycle %0d got %b expected %b", bad, rec_code[bad], exp_div(bad, 4));
      end
      n_cmp++;
      if (rec_busy[0] !== 1'b0) begin
         n_err++;
         $display("FAIL busy_one_cycle: got %b expected 0", rec_busy[0]);
      end
      $display("test_bypass_load done");
   endtask

   // ch0 running ratio 4, load 6 in the second HIGH cycle.
   task automatic test_mid_period_load();
      int bad;
      step();
      n_cmp++;
      if (cur_code[0] !== C_HI) begin
         n_err++;
         $display("FAIL ratio4_restart: got %b expected %b", cur_code[0], C_HI);
      end
      set_ratio(0, 6);
      bus.I_ratio_load[0] = 1'b1;
      step();
      n_cmp++;
      if (cur_busy[0] !== 1'b1 || cur_code[0] !== C_HI) begin
         n_err++;
         $display("FAIL mid_load_high: got busy=%b code=%b expected busy=1 code=%b", cur_busy[0], cur_code[0], C_HI);
      end
      bus.I_ratio_load[0] = 1'b0;
      record(0, 2);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (rec_code[k] !== C_LO || rec_busy[k] !== 1'b1) begin
            n_err++;
            $display("FAIL old_period_low cyc%0d: got code=%b busy=%b expected code=%b busy=1", k, rec_code[k], rec_busy[k], C_LO);
         end
      end
      record(0, 12);
      bad = -1;
      for (int k = 0; k < 12; k++) if (bad < 0 && (rec_code[k] !== exp_div(k, 6) || rec_busy[k] !== 1'b0)) bad = k;
      n_cmp++;
      if (bad >= 0) begin
         n_err++;
         $display("FAIL ratio6_wave: cycle %0d got code=%b busy=%b expected code=%b busy=0", bad, rec_code[bad], rec_busy[bad], exp_div(bad, 6));
      end
      $display("test_mid_period_load done");
   endtask

   // ch0: ratio 1 -> bypass, two loads last-wins, ratio 0 -> bypass, load at boundary.
   task automatic test_ratio_edge_cases();
      logic [1:0] exp_a [6];
      logic       bsy_a [6];
      logic [1:0] exp_b [7];
      logic       bsy_b [7];
      exp_a = '{C_HI, C_LO, C_LO, C_LO, C_BYP, C_BYP};
      bsy_a = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      exp_b = '{C_HI, C_HI, C_LO, C_LO, C_LO, C_BYP, C_BYP};
      bsy_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      // ratio 6 period starts at this edge; load 1 in its second HIGH cycle
      step();
      set_ratio(0, 1);
      bus.I_ratio_load[0] = 1'b1;
      step();
      bus.I_ratio_load[0] = 1'b0;
      record(0, 6);
      for (int k = 0; k < 6; k++) begin
         n_cmp++;
         if (rec_code[k] !== exp_a[k] || rec_busy[k] !== bsy_a[k]) begin
            n_err++;
            $display("FAIL ratio1_to_bypass cyc%0d: got code=%b busy=%b expected code=%b busy=%b", k, rec_code[k], rec_busy[k], exp_a[k], bsy_a[k]);
         end
      end

      // start ratio 5, then load 3 and 7 within the first period
      set_ratio(0, 5);
      bus.I_ratio_load[0] = 1'b1;
      step();
      bus.I_ratio_load[0] = 1'b0;
      step();
      n_cmp++;
      if (cur_code[0] !== C_HI || cur_busy[0] !== 1'b0) begin
         n_err++;
         $display("FAIL ratio5_start: got code=%b busy=%b expected code=%b busy=0", cur_code[0], cur_busy[0], C_HI);
      end
      set_ratio(0, 3);
      bus.I_ratio_load[0] = 1'b1;
      step();
      set_ratio(0, 7);
      step();
      bus.I_ratio_load[0] = 1'b0;
      record(0, 3);
      n_cmp++;
      if (rec_code[0] !== C_LO || rec_code[1] !== C_LO || rec_code[2] !== C_HI ||
          rec_busy[1] !== 1'b1 || rec_busy[2] !== 1'b0) begin
         n_err++;
         $display("FAIL last_load_wins_boundary: got codes %b %b %b busy %b %b expected codes 00 00 11 busy 1 0",
                  rec_code[0], rec_code[1], rec_code[2], rec_busy[1], rec_busy[2]);
      end
      // second cycle of the ratio-7 period: load 0
      set_ratio(0, 0);
      bus.I_ratio_load[0] = 1'b1;
      step();
      bus.I_ratio_load[0] = 1'b0;
      record(0, 7);
      for (int k = 0; k < 7; k++) begin
         n_cmp++;
         if (rec_code[k] !== exp_b[k] || rec_busy[k] !== bsy_b[k]) begin
            n_err++;
            $display("FAIL ratio7_then_0 cyc%0d: got code=%b busy=%b expected code=%b busy=%b", k, rec_code[k], rec_busy[k], exp_b[k], bsy_b[k]);
         end
      end

      // run ratio 4, load 3 exactly in the boundary cycle
      set_ratio(0, 4);
      bus.I_ratio_load[0] = 1'b1;
      step();
      bus.I_ratio_load[0] = 1'b0;
      step();
      step();
      step();
      step();
      n_cmp++;
      if (cur_code[0] !== C_LO) begin
         n_err++;
         $display("FAIL ratio4_last_low: got %b expected %b", cur_code[0], C_LO);
      end
      set_ratio(0, 3);
      bus.I_ratio_load[0] = 1'b1;
      step();
      bus.I_ratio_load[0] = 1'b0;
      n_cmp++;
      if (cur_code[0] !== C_HI || cur_busy[0] !== 1'b0) begin
         n_err++;
         $display("FAIL boundary_load: got code=%b busy=%b expected code=%b busy=0", cur_code[0], cur_busy[0], C_HI);
      end
      record(0, 5);
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if (rec_code[k] !== exp_div(k + 1, 3) || rec_busy[k] !== 1'b0) begin
            n_err++;
            $display("FAIL boundary_ratio3 cyc%0d: got code=%b busy=%b expected code=%b busy=0", k, rec_code[k], rec_busy[k], exp_div(k + 1, 3));
         end
      end
      $display("test_ratio_edge_cases done");
   endtask

   // ch1: ratios 5, 2 and 255 from bypass, stopping after two periods each.
   task automatic test_ratio_sweep();
      int ratios [3];
      int bad;
      int t0;
      int waited;
      ratios = '{5, 2, 255};
      foreach (ratios[i]) begin
         set_ratio(1, ratios[i]);
         bus.I_ratio_load[1] = 1'b1;
         bus.I_clk_en[1] = 1'b0;
         step();
         n_cmp++;
         if (cur_busy[1] !== 1'b1) begin
            n_err++;
            $display("FAIL sweep_busy r%0d: got %b expected 1", ratios[i], cur_busy[1]);
         end
         bus.I_ratio_load[1] = 1'b0;
         step();
         n_cmp++;
         if (cur_busy[1] !== 1'b0 || cur_code[1] !== C_BYP) begin
            n_err++;
            $display("FAIL sweep_applied r%0d: got busy=%b code=%b expected busy=0 code=%b", ratios[i], cur_busy[1], cur_code[1], C_BYP);
         end
         bus.I_clk_en[1] = 1'b1;
         t0 = tick_cnt[1];
         record(1, 2 * ratios[i]);
         bad = -1;
         for (int k = 0; k < 2 * ratios[i]; k++) if (bad < 0 && rec_code[k] !== exp_div(k, ratios[i])) bad = k;
         n_cmp++;
         if (bad >= 0) begin
            n_err++;
            $display("FAIL sweep_wave r%0d: cycle %0d got %b expected %b", ratios[i], bad, rec_code[bad], exp_div(bad, ratios[i]));
         end
`ifdef CLKDIV_TICK_EN
         n_cmp++;
         if (tick_cnt[1] - t0 !== 2) begin
            n_err++;
            $display("FAIL sweep_ticks r%0d: got %0d expected 2", ratios[i], tick_cnt[1] - t0);
         end
`endif
         bus.I_clk_en[1] = 1'b0;
         waited = 0;
         do begin
            step();
            waited++;
         end while (cur_code[1] !== C_BYP && waited < 300);
         n_cmp++;
         if (cur_code[1] !== C_BYP || waited !== 1) begin
            n_err++;
            $display("FAIL sweep_stop r%0d: got code=%b after %0d cycles expected code=%b after 1", ratios[i], cur_code[1], waited, C_BYP);
         end
      end
      $display("test_ratio_sweep done");
   endtask

   // ch1: enable dropped in the second HIGH cycle of ratio 8.
   task automatic test_disable_mid_period();
      logic [1:0] exp_c;
      set_ratio(1, 8);
      bus.I_ratio_load[1] = 1'b1;
      step();
      bus.I_ratio_load[1] = 1'b0;
      step();
      bus.I_clk_en[1] = 1'b1;
      step();
      bus.I_clk_en[1] = 1'b0;
      step();
      n_cmp++;
      if (cur_code[1] !== C_HI) begin
         n_err++;
         $display("FAIL disable_still_high: got %b expected %b", cur_code[1], C_HI);
      end
      record(1, 12);
      for (int k = 0; k < 12; k++) begin
         exp_c = (k < 2) ? C_HI : ((k < 6) ? C_LO : C_BYP);
         n_cmp++;
         if (rec_code[k] !== exp_c) begin
            n_err++;
            $display("FAIL disable_wave cyc%0d: got %b expected %b", k, rec_code[k], exp_c);
         end
      end
      $display("test_disable_mid_period done");
   endtask

   // Reset for one edge while ch0 (ratio 3) is in LOW and ch1 runs ratio 3.
   task automatic test_reset_mid_period();
      int waited;
      set_ratio(1, 3);
      bus.I_ratio_load[1] = 1'b1;
      step();
      bus.I_ratio_load[1] = 1'b0;
      step();
      bus.I_clk_en[1] = 1'b1;
      step();
      n_cmp++;
      if (cur_code[1] !== C_HI) begin
         n_err++;
         $display("FAIL ch1_ratio3_start: got %b expected %b", cur_code[1], C_HI);
      end
      waited = 0;
      while (cur_code[0] !== C_LO && waited < 10) begin
         step();
         waited++;
      end
      n_cmp++;
      if (cur_code[0] !== C_LO) begin
         n_err++;
         $display("FAIL ch0_low_wait: got %b expected %b within 10 cycles", cur_code[0], C_LO);
      end
      // a load coinciding with reset must not leave busy set
      set_ratio(1, 9);
      bus.I_ratio_load[1] = 1'b1;
      I_rst_n = 1'b0;
      step();
      bus.I_ratio_load[1] = 1'b0;
      I_rst_n = 1'b1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         n_cmp++;
         if (cur_code[ch] !== C_BYP || cur_busy[ch] !== 1'b0) begin
            n_err++;
            $display("FAIL midrun_reset ch%0d: got code=%b busy=%b expected code=%b busy=0", ch, cur_code[ch], cur_busy[ch], C_BYP);
         end
      end
      step();
      step();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         n_cmp++;
         if (cur_code[ch] !== C_BYP) begin
            n_err++;
            $display("FAIL post_reset_ratio0 ch%0d: got %b expected %b", ch, cur_code[ch], C_BYP);
         end
      end
      $display("test_reset_mid_period done");
   endtask

   initial begin
      for (int ch = 0; ch < NUM_CH; ch++) tick_cnt[ch] = 0;
      test_reset();
      test_bypass_load();
      test_mid_period_load();
      test_ratio_edge_cases();
      test_ratio_sweep();
      test_disable_mid_period();
      test_reset_mid_period();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_clk_div_multi
